fir_filter_tdm: RTL

FIR_FILTER_TDM -- requirements
Module: fir_filter_tdm

---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_tap_mem.sv | 59 +++++
 rtl/fir_filter_tdm.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// +--------------------------------------------------------------------+
// | fir_pkg : shared FSM state type and width helpers  (rev 1.0)       |
// +--------------------------------------------------------------------+
`default_nettype none

package fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } fir_state_e;

   // Full-precision output width: product plus growth for N+1 terms.
   function automatic int fir_width_y(input int wx, input int wb, input int n);
      return wx + wb + $clog2(n + 1);
   endfunction

   function automatic int fir_cw(input int c);
      return (c > 1) ? $clog2(c) : 1;
   endfunction

   function automatic int fir_kw(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fir_tap_mem.sv
// +--------------------------------------------------------------------+
// | fir_tap_mem : per-channel delay lines, shift-on-write, tap read    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fir_tap_mem import fir_pkg::*; #(
   parameter int N       = 3,
   parameter int C       = 2,
   parameter int WIDTH_X = 4,
   parameter int CW      = 1,
   parameter int KW      = 2
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      wr_en_i,
   input  logic [CW-1:0]             wr_chan_i,
   input  logic signed [WIDTH_X-1:0] wr_data_i,
   input  logic [CW-1:0]             rd_chan_i,
   input  logic [KW-1:0]             rd_tap_i,
   output logic signed [WIDTH_X-1:0] rd_data_o
);

   logic signed [WIDTH_X-1:0] z_q [C][N+1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < C; c++) begin
            for (int k = 0; k <= N; k++) begin
               z_q[c][k] <= '0;
            end
         end
      end else if (wr_en_i) begin
         for (int c = 0; c < C; c++) begin
            if (wr_chan_i == CW'(c)) begin
               z_q[c][0] <= wr_data_i;
               for (int k = 1; k <= N; k++) begin
                  z_q[c][k] <= z_q[c][k-1];
               end
            end
         end
      end
   end

   // Explicit mux keeps out-of-range channel/tap codes reading zero.
   always_comb begin
      rd_data_o = '0;
      for (int c = 0; c < C; c++) begin
         for (int k = 0; k <= N; k++) begin
            if (rd_chan_i == CW'(c) && rd_tap_i == KW'(k)) begin
               rd_data_o = z_q[c][k];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fir_filter_tdm.sv
// +--------------------------------------------------------------------+
// | fir_filter_tdm : C-channel TDM FIR on one MAC; FIR_COEF_LOAD_EN    |
// | enables runtime coefficient writes.  rev 1.0                       |
// +--------------------------------------------------------------------+
`default_nettype none

module fir_filter_tdm import fir_pkg::*; #(
   parameter int N       = 3,
   parameter int C       = 2,
   parameter int WIDTH_X = 4,
   parameter int WIDTH_B = 4,
   parameter logic [WIDTH_B*(N+1)-1:0] B = {4'd1, 4'd2, 4'd3, 4'd4},
   localparam int WIDTH_Y = fir_width_y(WIDTH_X, WIDTH_B, N),
   localparam int CW      = fir_cw(C),
   localparam int KW      = fir_kw(N)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [CW-1:0]             s_chan,
   input  logic signed [WIDTH_X-1:0] s_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [CW-1:0]             m_chan,
   output logic signed [WIDTH_Y-1:0] m_data,
   input  logic                      coef_we,
   input  logic [KW-1:0]             coef_addr,
   input  logic signed [WIDTH_B-1:0] coef_data,
   output logic                      coef_ready
);

   localparam int WP = WIDTH_X + WIDTH_B;

   fir_state_e                state_q, state_d;
   logic                      ready_q;
   logic [CW-1:0]             chan_q;
   logic [KW-1:0]             k_q;
   logic signed [WIDTH_Y-1:0] acc_q;
   logic signed [WIDTH_Y-1:0] m_data_q;
   logic [CW-1:0]             m_chan_q;

   logic                      w_accept;
   logic                      w_start;
   logic                      w_last;
   logic signed [WIDTH_X-1:0] w_tap;
   logic signed [WIDTH_B-1:0] w_coef;
   logic signed [WP-1:0]      w_prod;
   logic signed [WIDTH_Y-1:0] w_sum;
   logic signed [WIDTH_B-1:0] coef_tbl [N+1];

   assign w_accept = s_valid && s_ready;
   // Out-of-range channels complete the handshake but never start a MAC.
   assign w_start  = w_accept && (int'(s_chan) < C);
   assign w_last   = (k_q == KW'(N));

   fir_tap_mem #(
      .N       (N),
      .C       (C),
      .WIDTH_X (WIDTH_X),
      .CW      (CW),
      .KW      (KW)
   ) u_tap_mem (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (w_start),
      .wr_chan_i (s_chan),
      .wr_data_i (s_data),
      .rd_chan_i (chan_q),
      .rd_tap_i  (k_q),
      .rd_data_o (w_tap)
   );

`ifdef FIR_COEF_LOAD_EN
   logic signed [WIDTH_B-1:0] coef_q [N+1];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k <= N; k++) begin
            coef_q[k] <= B[WIDTH_B*k +: WIDTH_B];
         end
      end else if (coef_we && coef_ready) begin
         for (int k = 0; k <= N; k++) begin
            if (coef_addr == KW'(k)) begin
               coef_q[k] <= coef_data;
            end
         end
      end
   end

   always_comb begin
      for (int k = 0; k <= N; k++) begin
         coef_tbl[k] = coef_q[k];
      end
   end
`else
   logic unused_coef;
   assign unused_coef = ^{coef_we, coef_addr, coef_data};

   always_comb begin
      for (int k = 0; k <= N; k++) begin
         coef_tbl[k] = B[WIDTH_B*k +: WIDTH_B];
      end
   end
`endif

   always_comb begin
      w_coef = '0;
      for (int k = 0; k <= N; k++) begin
         if (k_q == KW'(k)) begin
            w_coef = coef_tbl[k];
         end
      end
   end

   assign w_prod = WP'(w_tap) * WP'(w_coef);
   assign w_sum  = acc_q + WIDTH_Y'(w_prod);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ready_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_start) state_d = ST_MAC;
         ST_MAC:  if (w_last)  state_d = ST_OUT;
         ST_OUT:  if (m_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready = ready_q && (state_q == ST_IDLE);
      m_valid = (state_q == ST_OUT);
`ifdef FIR_COEF_LOAD_EN
      coef_ready = (state_q == ST_IDLE);
`else
      coef_ready = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         chan_q   <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         m_data_q <= '0;
         m_chan_q <= '0;
      end else if (w_start) begin
         chan_q <= s_chan;
         k_q    <= '0;
         acc_q  <= '0;
      end else if (state_q == ST_MAC) begin
         acc_q <= w_sum;
         k_q   <= k_q + 1'b1;
         if (w_last) begin
            m_data_q <= w_sum;
            m_chan_q <= chan_q;
         end
      end
   end

   assign m_data = m_data_q;
   assign m_chan = m_chan_q;

endmodule

`default_nettype wire
